scoreboard_core: RTL

Parametrised game-timing and scoring engine for the FPGA scoreboard, replacing the fixed two-team, 12-minute/24-second counter. It generates its own 1 Hz tick, runs the game and shot clocks with expiry detection, tracks periods, keeps N saturating team scores with edge-detected point entry, and drives a timed buzzer. It sits between the switch/pushbutton front end and the binary-to-BCD/7-segment display path.

---
 rtl/scoreboard_core_pkg.sv | 17 +
 rtl/scoreboard_core_if.sv | 35 +++
 rtl/scoreboard_core_tick_gen.sv | 30 +++
 rtl/scoreboard_core.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_core_pkg.sv
// Shared widths and helpers for the scoreboard timing/scoring engine.
// Display-facing fields keep fixed widths so the BCD path never has to change.
package scoreboard_core_pkg;

  localparam int MINS_W   = 7;
  localparam int SECS_W   = 6;
  localparam int SHOT_W   = 6;
  localparam int PERIOD_W = 3;

  localparam logic [SECS_W-1:0] SECS_TOP = 6'd59;

  // A zero point value from the front end still scores one point.
  function automatic logic [1:0] pts_decode(input logic [1:0] pts);
    return (pts == 2'd0) ? 2'd1 : pts;
  endfunction

endpackage

// File: rtl/scoreboard_core_if.sv
// Front-end controls in, clock/score/flag state out to the display path.
interface scoreboard_core_if #(
  parameter int NUM_TEAMS = 2,
  parameter int SCORE_W   = 8
);
  import scoreboard_core_pkg::*;

  logic                          run;
  logic                          shot_rst;
  logic                          next_period;
  logic                          game_rst;
  logic [1:0]                    pts;
  logic [NUM_TEAMS-1:0]          score_inc;
  logic [NUM_TEAMS-1:0]          score_dec;
  logic [MINS_W-1:0]             mins;
  logic [SECS_W-1:0]             secs;
  logic [SHOT_W-1:0]             shot;
  logic [PERIOD_W-1:0]           period;
  logic [NUM_TEAMS*SCORE_W-1:0]  scores;
  logic                          period_end;
  logic                          shot_viol;
  logic                          game_over;
  logic                          buzzer;

  modport master (
    output run, shot_rst, next_period, game_rst, pts, score_inc, score_dec,
    input  mins, secs, shot, period, scores, period_end, shot_viol, game_over, buzzer
  );

  modport slave (
    input  run, shot_rst, next_period, game_rst, pts, score_inc, score_dec,
    output mins, secs, shot, period, scores, period_end, shot_viol, game_over, buzzer
  );

endinterface

// File: rtl/scoreboard_core_tick_gen.sv
// One-second prescaler: counts only while enabled, holds a partial second
// when paused, and pulses tick in the cycle the count wraps.
module scoreboard_core_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              CNT_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/scoreboard_core.sv
// Game/shot clock countdown, period sequencing, saturating team scores and
// buzzer timing for the FPGA scoreboard.
module scoreboard_core
  import scoreboard_core_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int PERIOD_MIN  = 12,
  parameter int SHOT_SEC    = 24,
  parameter int NUM_PERIODS = 4,
  parameter int NUM_TEAMS   = 2,
  parameter int SCORE_W     = 8,
  parameter int SCORE_MAX   = 199,
  parameter int BUZZ_CYC    = 25_000_000
) (
  input logic               CLK,
  input logic               RST_N,
  scoreboard_core_if.slave  bus
);

  localparam logic [MINS_W-1:0]   MINS_RLD  = MINS_W'(PERIOD_MIN);
  localparam logic [SHOT_W-1:0]   SHOT_RLD  = SHOT_W'(SHOT_SEC);
  localparam logic [PERIOD_W-1:0] LAST_PER  = PERIOD_W'(NUM_PERIODS);
  localparam int                  BUZZ_W    = $clog2(BUZZ_CYC + 1);
  localparam logic [BUZZ_W-1:0]   BUZZ_LOAD = BUZZ_W'(BUZZ_CYC);
  localparam logic [SCORE_W+1:0]  SMAX_X    = (SCORE_W + 2)'(SCORE_MAX);

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [1:0] p);
    logic [SCORE_W+1:0] sum;
    sum = {2'b00, s} + {{SCORE_W{1'b0}}, p};
    return (sum > SMAX_X) ? SCORE_W'(SMAX_X) : SCORE_W'(sum);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] s,
                                                 input logic [1:0] p);
    logic [SCORE_W+1:0] diff;
    diff = {2'b00, s} - {{SCORE_W{1'b0}}, p};
    return ({2'b00, s} < {{SCORE_W{1'b0}}, p}) ? '0 : SCORE_W'(diff);
  endfunction

  logic [MINS_W-1:0]   mins_q,   mins_d;
  logic [SECS_W-1:0]   secs_q,   secs_d;
  logic [SHOT_W-1:0]   shot_q,   shot_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pend_q,   pend_d;
  logic                sviol_q,  sviol_d;
  logic                gover_q,  gover_d;
  logic [BUZZ_W-1:0]   buzz_q,   buzz_d;
  logic                buzzer_q;
  logic                np_p0;
  logic                np_go;
  logic                tick;

  assign np_go = bus.next_period && !np_p0 && pend_q && !gover_q;

  scoreboard_core_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (bus.game_rst || np_go),
    .en    (bus.run && !pend_q && !gover_q),
    .tick  (tick)
  );

  // Clock control, highest priority first: game reset, new period, shot reload, countdown.
  always_comb begin
    mins_d   = mins_q;
    secs_d   = secs_q;
    shot_d   = shot_q;
    period_d = period_q;
    pend_d   = pend_q;
    sviol_d  = sviol_q;
    gover_d  = gover_q;
    if (bus.game_rst) begin
      mins_d   = MINS_RLD;
      secs_d   = '0;
      shot_d   = SHOT_RLD;
      period_d = PERIOD_W'(1);
      pend_d   = 1'b0;
      sviol_d  = 1'b0;
      gover_d  = 1'b0;
    end else if (np_go) begin
      mins_d   = MINS_RLD;
      secs_d   = '0;
      shot_d   = SHOT_RLD;
      period_d = period_q + 1'b1;
      pend_d   = 1'b0;
      sviol_d  = 1'b0;
    end else begin
      if (bus.shot_rst) begin
        shot_d  = SHOT_RLD;
        sviol_d = 1'b0;
      end else if (tick && shot_q != '0 && !sviol_q) begin
        shot_d = shot_q - 1'b1;
        if (shot_q == SHOT_W'(1)) sviol_d = 1'b1;
      end
      if (tick) begin
        if (secs_q == '0 && mins_q != '0) begin
          secs_d = SECS_TOP;
          mins_d = mins_q - 1'b1;
        end else begin
          secs_d = secs_q - 1'b1;
        end
        if (mins_q == '0 && secs_q == SECS_W'(1)) begin
          pend_d = 1'b1;
          if (period_q == LAST_PER) gover_d = 1'b1;
        end
      end
    end

    // Both flags rising together still yields a single reload of the pulse.
    buzz_d = '0;
    if (bus.game_rst)                                   buzz_d = '0;
    else if ((pend_d && !pend_q) || (sviol_d && !sviol_q)) buzz_d = BUZZ_LOAD;
    else if (buzz_q != '0)                              buzz_d = buzz_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mins_q   <= MINS_RLD;
      secs_q   <= '0;
      shot_q   <= SHOT_RLD;
      period_q <= PERIOD_W'(1);
      pend_q   <= 1'b0;
      sviol_q  <= 1'b0;
      gover_q  <= 1'b0;
      buzz_q   <= '0;
      buzzer_q <= 1'b0;
      np_p0    <= 1'b0;
    end else begin
      mins_q   <= mins_d;
      secs_q   <= secs_d;
      shot_q   <= shot_d;
      period_q <= period_d;
      pend_q   <= pend_d;
      sviol_q  <= sviol_d;
      gover_q  <= gover_d;
      buzz_q   <= buzz_d;
      buzzer_q <= (buzz_d != '0);
      np_p0    <= bus.game_rst ? 1'b0 : bus.next_period;
    end
  end

  assign bus.mins       = mins_q;
  assign bus.secs       = secs_q;
  assign bus.shot       = shot_q;
  assign bus.period     = period_q;
  assign bus.period_end = pend_q;
  assign bus.shot_viol  = sviol_q;
  assign bus.game_over  = gover_q;
  assign bus.buzzer     = buzzer_q;

  // Score path: _p0 delays the raw input, _p1 holds the detected edge and its point value.
  for (genvar t = 0; t < NUM_TEAMS; t++) begin : g_team
    logic               inc_p0, dec_p0;
    logic               inc_p1, dec_p1;
    logic [1:0]         pts_p1;
    logic [SCORE_W-1:0] score_q;

    always_ff @(posedge CLK) begin
      pts_p1 <= pts_decode(bus.pts);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        inc_p0  <= 1'b0;
        dec_p0  <= 1'b0;
        inc_p1  <= 1'b0;
        dec_p1  <= 1'b0;
        score_q <= '0;
      end else if (bus.game_rst) begin
        inc_p0  <= 1'b0;
        dec_p0  <= 1'b0;
        inc_p1  <= 1'b0;
        dec_p1  <= 1'b0;
        score_q <= '0;
      end else begin
        inc_p0 <= bus.score_inc[t];
        dec_p0 <= bus.score_dec[t];
        inc_p1 <= bus.score_inc[t] && !inc_p0;
        dec_p1 <= bus.score_dec[t] && !dec_p0;
        if (!gover_q) begin
          if (inc_p1 && !dec_p1)      score_q <= sat_add(score_q, pts_p1);
          else if (dec_p1 && !inc_p1) score_q <= sat_sub(score_q, pts_p1);
        end
      end
    end

    assign bus.scores[t*SCORE_W +: SCORE_W] = score_q;
  end

endmodule
